// File: rtl/words_pkg.sv
// Shared defaults and slot placement for the word-to-block packer.
package words_pkg;

    localparam int WORD_W_DEF          = 32;
    localparam int WORDS_PER_BLOCK_DEF = 4;

    // Bit offset of the low end of a word slot inside a block.
    // Slot 0 is the first word of the block. With msb_first set it sits at the top.
    function automatic int unsigned slot_lo(input int unsigned slot,
                                            input int unsigned words,
                                            input int unsigned word_w,
                                            input int unsigned msb_first);
        if (msb_first != 0) begin
            return (words - 1 - slot) * word_w;
        end
        return slot * word_w;
    endfunction

endpackage

// File: rtl/words_block_packer_vr_reg_slice.sv
// One-entry valid/ready holding register. Accepts new data while draining,
// so a full slice still sustains one transfer per cycle.
module vr_reg_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load on input handshake, otherwise drop valid once the consumer takes it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register; data stays put while valid and not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/words_block_packer.sv
// Packs WORDS_PER_BLOCK words into one block, closing early on word_last.
// A partial block is zero padded. Output goes through a one-block slice.
module words_block_packer
    import words_pkg::*;
#(
    parameter int WORD_W          = WORD_W_DEF,
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int MSB_FIRST       = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   word_valid,
    output logic                                   word_ready,
    input  logic [WORD_W-1:0]                      word,
    input  logic                                   word_last,
    output logic                                   block_valid,
    input  logic                                   block_ready,
    output logic [WORD_W*WORDS_PER_BLOCK-1:0]      block,
    output logic [$clog2(WORDS_PER_BLOCK+1)-1:0]   block_words,
    output logic                                   block_last
);

    localparam int BLK_W = WORD_W * WORDS_PER_BLOCK;
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);
    localparam int DW    = 1 + CNT_W + BLK_W;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS_PER_BLOCK - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [BLK_W-1:0] acc_q,   acc_d;
    logic [BLK_W-1:0] acc_merged;
    logic             closing;
    logic             accept;
    logic             slice_in_ready;
    logic [DW-1:0]    slice_in_data;
    logic [DW-1:0]    slice_out_data;

    // A closing word needs room in the slice; other words only touch the accumulator.
    assign closing    = (count_q == LAST_SLOT) || word_last;
    assign word_ready = !rst && !(closing && !slice_in_ready);
    assign accept     = word_valid && word_ready;

    // Unwritten slots are always zero, so OR-ing the shifted word places it.
    assign acc_merged = acc_q |
        ({{(BLK_W-WORD_W){1'b0}}, word} <<
         slot_lo(32'(count_q), WORDS_PER_BLOCK, WORD_W, MSB_FIRST));

    assign slice_in_data = {word_last, count_q + CNT_W'(1), acc_merged};

    // Accumulator next state: advance on a plain word, clear on close.
    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        if (accept) begin
            if (closing) begin
                count_d = '0;
                acc_d   = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
                acc_d   = acc_merged;
            end
        end
    end

    // Accumulator state; reset discards any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    vr_reg_slice #(.DW(DW)) u_out (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept && closing),
        .in_ready  (slice_in_ready),
        .in_data   (slice_in_data),
        .out_valid (block_valid),
        .out_ready (block_ready),
        .out_data  (slice_out_data)
    );

    assign {block_last, block_words, block} = slice_out_data;

endmodule

// File: tb/tb_words_block_packer.sv
module tb_words_block_packer;

    localparam int WW  = 32;
    localparam int WPB = 4;
    localparam int BW  = WW * WPB;
    localparam int CW  = 3;

    typedef struct packed {
        logic [BW-1:0] blk;
        logic [CW-1:0] n;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          word_valid, word_ready, word_last;
    logic [WW-1:0] word;
    logic          block_valid, block_ready, block_last;
    logic [BW-1:0] block;
    logic [CW-1:0] block_words;

    logic          l_word_valid, l_word_ready, l_word_last;
    logic [WW-1:0] l_word;
    logic          l_block_valid, l_block_ready, l_block_last;
    logic [BW-1:0] l_block;
    logic [CW-1:0] l_block_words;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    words_block_packer #(.WORD_W(WW), .WORDS_PER_BLOCK(WPB), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .word_valid(word_valid), .word_ready(word_ready), .word(word), .word_last(word_last),
        .block_valid(block_valid), .block_ready(block_ready), .block(block),
        .block_words(block_words), .block_last(block_last)
    );

    words_block_packer #(.WORD_W(WW), .WORDS_PER_BLOCK(WPB), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .word_valid(l_word_valid), .word_ready(l_word_ready), .word(l_word), .word_last(l_word_last),
        .block_valid(l_block_valid), .block_ready(l_block_ready), .block(l_block),
        .block_words(l_block_words), .block_last(l_block_last)
    );

    // Scoreboard: every block handed to the consumer must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && block_valid && block_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got block=%h words=%0d last=%0b, none expected",
                         block, block_words, block_last);
            end else begin
                e = sb.pop_front();
                if ({block, block_words, block_last} !== {e.blk, e.n, e.last}) begin
                    miscompares++;
                    $display("FAIL sb_block: got %h/%0d/%0b want %h/%0d/%0b",
                             block, block_words, block_last, e.blk, e.n, e.last);
                end
            end
        end
    end

    // Present one word and hold it until accepted; returns the stall count.
    task automatic send_word(input logic [WW-1:0] w, input logic last, output int waits);
        waits = 0;
        word_valid = 1'b1;
        word       = w;
        word_last  = last;
        forever begin
            @(negedge clk);
            if (word_ready) break;
            waits++;
            if (waits >= 50) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        word_last  = 1'b0;
        if (waits >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        word_valid = 0; word_last = 0; word = '0; block_ready = 0;
        l_word_valid = 0; l_word_last = 0; l_word = '0; l_block_ready = 0;
        idle(2);
        vectors++;
        if ({block_valid, block, block_words, block_last, word_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%0b block=%h words=%0d last=%0b ready=%0b, want all 0",
                     block_valid, block, block_words, block_last, word_ready);
        end
        vectors++;
        if ({l_block_valid, l_block, l_word_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_lsb: valid=%0b block=%h ready=%0b, want all 0",
                     l_block_valid, l_block, l_word_ready);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_stream();
        logic [WW-1:0] ws[8] = '{32'h01234567, 32'h89ABCDEF, 32'hA0A0A0A0, 32'hF9F9F9F9,
                                 32'h76543210, 32'hFEDCBA98, 32'hB1B1B1B1, 32'hE8E8E8E8};
        logic [BW-1:0] b1 = 128'h0123456789ABCDEFA0A0A0A0F9F9F9F9;
        logic [BW-1:0] b2 = 128'h76543210FEDCBA98B1B1B1B1E8E8E8E8;
        int w, stalls;
        stalls = 0;
        block_ready = 1'b1;
        sb.push_back('{b1, 3'd4, 1'b0});
        sb.push_back('{b2, 3'd4, 1'b0});
        for (int i = 0; i < 8; i++) begin
            send_word(ws[i], 1'b0, w);
            stalls += w;
            if (i == 3 || i == 7) begin
                vectors++;
                if (block_valid !== 1'b1 || block !== ((i == 3) ? b1 : b2)) begin
                    miscompares++;
                    $display("FAIL stream_latency%0d: valid=%0b block=%h", i, block_valid, block);
                end
            end
        end
        vectors++;
        if (stalls != 0) begin
            miscompares++;
            $display("FAIL stream_ready: %0d stall cycles, want 0", stalls);
        end
        idle(2);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL stream_drain: %0d blocks pending, want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] ws[8] = '{32'h01234567, 32'h89ABCDEF, 32'hA0A0A0A0, 32'hF9F9F9F9,
                                 32'h76543210, 32'hFEDCBA98, 32'hB1B1B1B1, 32'hE8E8E8E8};
        logic [BW-1:0] b1 = 128'h0123456789ABCDEFA0A0A0A0F9F9F9F9;
        logic [BW-1:0] b2 = 128'h76543210FEDCBA98B1B1B1B1E8E8E8E8;
        int w, stalls;
        stalls = 0;
        block_ready = 1'b0;
        sb.push_back('{b1, 3'd4, 1'b0});
        sb.push_back('{b2, 3'd4, 1'b0});
        for (int i = 0; i < 7; i++) begin
            send_word(ws[i], 1'b0, w);
            stalls += w;
        end
        vectors++;
        if (stalls != 0) begin
            miscompares++;
            $display("FAIL bp_accept7: %0d stall cycles, want 0", stalls);
        end
        word_valid = 1'b1;
        word = ws[7];
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (word_ready !== 1'b0 || block_valid !== 1'b1 || block !== b1) begin
                miscompares++;
                $display("FAIL bp_hold: ready=%0b valid=%0b block=%h want 0/1/%h",
                         word_ready, block_valid, block, b1);
            end
            @(posedge clk); #1;
        end
        block_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (word_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_pulse_ready: word_ready=%0b want 1", word_ready);
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        block_ready = 1'b0;
        vectors++;
        if (block_valid !== 1'b1 || block !== b2 || block_words !== 3'd4) begin
            miscompares++;
            $display("FAIL bp_reload: valid=%0b block=%h words=%0d want 1/%h/4",
                     block_valid, block, block_words, b2);
        end
        block_ready = 1'b1;
        idle(2);
        vectors++;
        if (sb.size() != 0 || block_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: pending=%0d valid=%0b want 0/0", sb.size(), block_valid);
        end
    endtask

    task automatic test_partial();
        int w;
        block_ready = 1'b1;
        sb.push_back('{128'h11111111222222220000000000000000, 3'd2, 1'b1});
        send_word(32'h11111111, 1'b0, w);
        send_word(32'h22222222, 1'b1, w);
        vectors++;
        if (block_valid !== 1'b1 || block_words !== 3'd2 || block_last !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_close: valid=%0b words=%0d last=%0b want 1/2/1",
                     block_valid, block_words, block_last);
        end
        sb.push_back('{128'hAAAAAAAA000000000000000000000000, 3'd1, 1'b1});
        send_word(32'hAAAAAAAA, 1'b1, w);
        sb.push_back('{128'hC0000001C0000002C0000003C0000004, 3'd4, 1'b1});
        for (int i = 1; i <= 4; i++) send_word(32'hC0000000 | i, (i == 4), w);
        idle(2);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL partial_drain: %0d blocks pending, want 0", sb.size());
        end
    endtask

    task automatic test_lsb_first();
        l_block_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            l_word_valid = 1'b1;
            l_word = WW'(i);
            @(negedge clk);
            vectors++;
            if (l_word_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL lsb_ready%0d: word_ready=%0b want 1", i, l_word_ready);
            end
            @(posedge clk); #1;
        end
        l_word_valid = 1'b0;
        vectors++;
        if (l_block_valid !== 1'b1 || l_block !== 128'h00000004000000030000000200000001 ||
            l_block_words !== 3'd4 || l_block_last !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_block: valid=%0b block=%h words=%0d last=%0b",
                     l_block_valid, l_block, l_block_words, l_block_last);
        end
        idle(2);
    endtask

    task automatic test_mid_reset();
        int w;
        block_ready = 1'b1;
        send_word(32'h0BADF00D, 1'b0, w);
        send_word(32'h0BADCAFE, 1'b0, w);
        rst = 1'b1;
        word_valid = 1'b1;
        word = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if (word_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ready: word_ready=%0b want 0", word_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (block_valid !== 1'b0 || word_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_valid: valid=%0b ready=%0b want 0/0", block_valid, word_ready);
        end
        rst = 1'b0;
        word_valid = 1'b0;
        sb.push_back('{128'h5A5A5A5A5A5A5A5B5A5A5A5C5A5A5A5D, 3'd4, 1'b0});
        for (int i = 0; i < 4; i++) send_word(32'h5A5A5A5A + i, 1'b0, w);
        vectors++;
        if (block_valid !== 1'b1 || block_words !== 3'd4) begin
            miscompares++;
            $display("FAIL rst_newblock: valid=%0b words=%0d want 1/4", block_valid, block_words);
        end
        idle(2);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rst_drain: %0d blocks pending, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_partial();
        test_lsb_first();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
